// File: rtl/pipe_stage_reg_if.sv
// Bus between a pipeline stage and its inter-stage register: stage control,
// per-lane write enables and lane data in, registered lanes and ready out.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2
);
  logic                          stall;
  logic                          flush;
  logic                          in_valid;
  logic [LANES-1:0]              lane_we;
  logic [LANES-1:0][DATA_W-1:0]  in_data;
  logic                          out_valid;
  logic [LANES-1:0][DATA_W-1:0]  out_data;
  logic                          in_ready;

  modport master (
    output stall, flush, in_valid, lane_we, in_data,
    input  out_valid, out_data, in_ready
  );

  modport slave (
    input  stall, flush, in_valid, lane_we, in_data,
    output out_valid, out_data, in_ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: LANES data lanes plus valid, with stall/flush
// control, per-lane write enables and saturating debug event counters.

module pipe_stage_lane #(
  parameter int DATA_W     = 32,
  parameter bit FLUSH_KEEP = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // Priority rst > flush > stall > load; a kept flush simply holds the lane.
  always_ff @(posedge clk) begin
    if (rst)                  q <= '0;
    else if (flush) begin
      if (!FLUSH_KEEP)        q <= '0;
    end
    else if (!stall && we)    q <= d;
  end
endmodule

module pipe_stage_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + CNT_W'(1);
  end
endmodule

module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int LANES      = 2,
  parameter bit FLUSH_KEEP = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stage_reg_if.slave    bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);
  logic                         vld_q;
  logic [LANES-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst)             vld_q <= 1'b0;
    else if (bus.flush)  vld_q <= 1'b0;
    else if (!bus.stall) vld_q <= bus.in_valid;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pipe_stage_lane #(.DATA_W(DATA_W), .FLUSH_KEEP(FLUSH_KEEP)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .stall (bus.stall),
      .we    (bus.lane_we[i]),
      .d     (bus.in_data[i]),
      .q     (data_q[i])
    );
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  // Ready is a pure function of stage control so it never closes a loop through data.
  assign bus.in_ready  = ~bus.stall | bus.flush;

  pipe_stage_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk), .rst (rst), .inc (bus.stall & ~bus.flush), .cnt (stall_cnt)
  );
  pipe_stage_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .inc (bus.flush), .cnt (flush_cnt)
  );
  // Bubble counts the valid seen before the edge, i.e. the register's own output.
  pipe_stage_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk), .rst (rst), .inc (~vld_q), .cnt (bubble_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a FLUSH_KEEP=0/CNT_W=16 and a FLUSH_KEEP=1/CNT_W=4
// instance share stimulus; a vector table, random traffic and corner sequences.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int LN = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  stall = 1'b0, flush = 1'b0, iv = 1'b0;
  logic [LN-1:0]         we = '0;
  logic [LN-1:0][DW-1:0] din = '0;
  logic [15:0]           sc0, fc0, bc0;
  logic [3:0]            sc1, fc1, bc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .LANES(LN)) b0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .LANES(LN)) b1 ();

  assign b0.stall = stall;  assign b0.flush = flush;  assign b0.in_valid = iv;
  assign b0.lane_we = we;   assign b0.in_data = din;
  assign b1.stall = stall;  assign b1.flush = flush;  assign b1.in_valid = iv;
  assign b1.lane_we = we;   assign b1.in_data = din;

  pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .FLUSH_KEEP(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave),
    .stall_cnt(sc0), .flush_cnt(fc0), .bubble_cnt(bc0)
  );
  pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .FLUSH_KEEP(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave),
    .stall_cnt(sc1), .flush_cnt(fc1), .bubble_cnt(bc1)
  );

  // Reference model: architectural state of each configuration, advanced per edge.
  logic          mv [2];
  logic [DW-1:0] md [2][LN];
  int            msc[2], mfc[2], mbc[2];
  int            mmax[2];
  bit            mkeep[2];

  function automatic int sat_inc(int v, int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mv[k] = 1'b0; msc[k] = 0; mfc[k] = 0; mbc[k] = 0;
        for (int i = 0; i < LN; i++) md[k][i] = '0;
      end else begin
        if (!mv[k]) mbc[k] = sat_inc(mbc[k], mmax[k]);
        if (flush) mfc[k] = sat_inc(mfc[k], mmax[k]);
        else if (stall) msc[k] = sat_inc(msc[k], mmax[k]);
        if (flush) begin
          mv[k] = 1'b0;
          if (!mkeep[k]) for (int i = 0; i < LN; i++) md[k][i] = '0;
        end else if (!stall) begin
          mv[k] = iv;
          for (int i = 0; i < LN; i++) if (we[i]) md[k][i] = din[i];
        end
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(string tag, int k, logic ov, logic [LN-1:0][DW-1:0] od,
                     int sc, int fc, int bc);
    logic [LN-1:0][DW-1:0] e;
    for (int i = 0; i < LN; i++) e[i] = md[k][i];
    chk({tag, ".out_valid"}, 64'(ov), 64'(mv[k]));
    chk({tag, ".out_data"}, 64'(od), 64'(e));
    chk({tag, ".stall_cnt"}, 64'(sc), 64'(msc[k]));
    chk({tag, ".flush_cnt"}, 64'(fc), 64'(mfc[k]));
    chk({tag, ".bubble_cnt"}, 64'(bc), 64'(mbc[k]));
  endtask

  // One cycle: ready check on settled inputs, edge, model step, model compare.
  task automatic tick(bit use_model);
    #1;
    chk("u0.in_ready", 64'(b0.in_ready), (stall && !flush) ? 64'd0 : 64'd1);
    chk("u1.in_ready", 64'(b1.in_ready), (stall && !flush) ? 64'd0 : 64'd1);
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) begin
      cmp("u0", 0, b0.out_valid, b0.out_data, int'(sc0), int'(fc0), int'(bc0));
      cmp("u1", 1, b1.out_valid, b1.out_data, int'(sc1), int'(fc1), int'(bc1));
    end
  endtask

  typedef struct {
    bit          rst, stall, flush, iv;
    bit [1:0]    we;
    logic [63:0] d;
    bit          ov;
    logic [63:0] od;
    int          sc, fc, bc;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit f, bit v, bit [1:0] w, logic [63:0] d,
                              bit ov, logic [63:0] od, int sc, int fc, int bc);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.iv = v; t.we = w; t.d = d;
    t.ov = ov; t.od = od; t.sc = sc; t.fc = fc; t.bc = bc;
    return t;
  endfunction

  vec_t tv[14];

  initial begin
    mmax[0] = 65535; mmax[1] = 15;
    mkeep[0] = 1'b0; mkeep[1] = 1'b1;
    mv[0] = 1'b0; mv[1] = 1'b0;

    // Expected values are for u0 (FLUSH_KEEP=0, 16-bit counters).
    tv[0]  = mk(1,0,0,0,2'b00,64'h0,                  0,64'h0,                  0,0,0);
    tv[1]  = mk(1,0,0,0,2'b00,64'h0,                  0,64'h0,                  0,0,0);
    tv[2]  = mk(0,0,0,1,2'b11,64'h8C010004_00400004,  1,64'h8C010004_00400004,  0,0,1);
    tv[3]  = mk(0,1,0,0,2'b11,64'h12345678_9ABCDEF0,  1,64'h8C010004_00400004,  1,0,1);
    tv[4]  = mk(0,1,0,1,2'b11,64'h0F0F0F0F_F0F0F0F0,  1,64'h8C010004_00400004,  2,0,1);
    tv[5]  = mk(0,1,0,1,2'b01,64'hCAFEBABE_01234567,  1,64'h8C010004_00400004,  3,0,1);
    tv[6]  = mk(0,1,1,1,2'b11,64'h77777777_88888888,  0,64'h0,                  3,1,1);
    tv[7]  = mk(0,0,0,1,2'b11,64'hAAAAAAAA_BBBBBBBB,  1,64'hAAAAAAAA_BBBBBBBB,  3,1,2);
    tv[8]  = mk(0,0,0,1,2'b01,64'h11111111_22222222,  1,64'hAAAAAAAA_22222222,  3,1,2);
    tv[9]  = mk(0,0,0,0,2'b10,64'h33333333_44444444,  0,64'h33333333_22222222,  3,1,2);
    tv[10] = mk(0,0,0,1,2'b00,64'h55555555_66666666,  1,64'h33333333_22222222,  3,1,3);
    tv[11] = mk(0,0,1,1,2'b11,64'h99999999_99999999,  0,64'h0,                  3,2,3);
    tv[12] = mk(1,1,1,1,2'b11,64'h12121212_34343434,  0,64'h0,                  0,0,0);
    tv[13] = mk(0,1,0,1,2'b11,64'h56565656_78787878,  0,64'h0,                  1,0,1);

    for (int n = 0; n < 14; n++) begin
      rst = tv[n].rst; stall = tv[n].stall; flush = tv[n].flush; iv = tv[n].iv;
      we = tv[n].we; din = tv[n].d;
      tick(n >= 2);
      chk($sformatf("vec%0d.out_valid", n), 64'(b0.out_valid), 64'(tv[n].ov));
      chk($sformatf("vec%0d.out_data", n),  64'(b0.out_data),  tv[n].od);
      chk($sformatf("vec%0d.stall_cnt", n), 64'(sc0), 64'(tv[n].sc));
      chk($sformatf("vec%0d.flush_cnt", n), 64'(fc0), 64'(tv[n].fc));
      chk($sformatf("vec%0d.bubble_cnt", n), 64'(bc0), 64'(tv[n].bc));
    end

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 2) == 0);
      iv    = 1'($urandom);
      we    = LN'($urandom);
      din   = {$urandom, $urandom};
      tick(1);
    end

    // Kept flush: valid drops, lanes hold on u1; u0 zeroes.
    rst = 0; stall = 0; flush = 0; iv = 1; we = 2'b11;
    din = {32'hDEADBEEF, 32'hDEADBEEF};
    tick(1);
    flush = 1; din = {32'h0BADF00D, 32'h0BADF00D};
    tick(1);
    chk("keep.u1.out_valid", 64'(b1.out_valid), 64'd0);
    chk("keep.u1.out_data",  64'(b1.out_data),  64'hDEADBEEF_DEADBEEF);
    chk("keep.u0.out_data",  64'(b0.out_data),  64'd0);

    // Counter saturation on a long stall, then reset asserted mid-stall.
    flush = 0; rst = 1;
    tick(1);
    rst = 0; stall = 1;
    for (int n = 0; n < 20; n++) begin
      din = {$urandom, $urandom};
      tick(1);
    end
    chk("sat.u1.stall_cnt", 64'(sc1), 64'hF);
    chk("sat.u0.stall_cnt", 64'(sc0), 64'd20);
    chk("sat.u1.bubble_cnt", 64'(bc1), 64'hF);
    rst = 1;
    tick(1);
    chk("rststall.u1.stall_cnt",  64'(sc1), 64'd0);
    chk("rststall.u1.bubble_cnt", 64'(bc1), 64'd0);
    chk("rststall.u0.stall_cnt",  64'(sc0), 64'd0);
    chk("rststall.u0.out_valid",  64'(b0.out_valid), 64'd0);
    rst = 0;
    tick(1);
    chk("afterrst.u1.stall_cnt", 64'(sc1), 64'd1);
    chk("afterrst.u0.bubble_cnt", 64'(bc0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
